tuart_tx: RTL and testbench
===========================

Name: tuart_tx

Overview:
Tiny-UART transmitter for the SUMP link. Sends logic-analyzer results (sample words, ID and metadata replies) from the LogIP core to the host. Accepts up to DATA_WORDS words of WORD_BITS each in one strobe and serialises them LSB-word first. Frame format is 1 start bit, WORD_BITS data bits LSB first, 1 stop bit. There is no flow control.

Parameters:
WORD_BITS, 8, data bits per UART frame
DATA_WORDS, 4, maximum words sent per request (SUMP sample width 32 bit)
CLK_PER_SAMPLE, 10, clk_i cycles per UART bit time (>= 2)

Ports:
clk_i  input  1  system clock
rst_in  input  1  system reset, asynchronous, active-low
data_i  input  WORD_BITS*DATA_WORDS  payload; word 0 = data_i[WORD_BITS-1:0], sent first
nwords_i  input  $clog2(DATA_WORDS+1)  number of words to send, 1..DATA_WORDS
stb_i  input  1  request; accepted only when rdy_o=1
rdy_o  output  1  transmitter idle, can accept a request
done_o  output  1  one-cycle pulse, last stop bit complete
tx_o  output  1  serial UART line, idle high

Behaviour:
- One clock, clk_i. Reset rst_in is asynchronous and active-low. All state is cleared on reset, not on the next clock edge.
- Reset values: tx_o=1, rdy_o=1, done_o=0, state=IDLE, all counters 0, shift register 0.
- tx_o, rdy_o and done_o are driven from registers; no combinational path from inputs to outputs.
- Acceptance: when stb_i=1 and rdy_o=1 at a clk_i edge, the core latches data_i and the clamped word count in that cycle.
  - Clamp: nwords_i>DATA_WORDS is treated as DATA_WORDS.
  - nwords_i=0: request is ignored. rdy_o stays 1, no done_o pulse.
- stb_i while rdy_o=0 is ignored; the bit stream in flight is unaffected.
- Latency: tx_o falls to 0 on the first edge after acceptance (1-cycle latency). rdy_o falls on the same edge.
- FSM states:
  - IDLE: tx_o=1. A valid strobe moves to START.
  - START: tx_o=0 for CLK_PER_SAMPLE cycles, then DATA.
  - DATA: drive the shift-register LSB for CLK_PER_SAMPLE cycles, shift right by 1, repeat WORD_BITS times, then STOP.
  - STOP: tx_o=1 for CLK_PER_SAMPLE cycles. Then:
    - if words remain, go to START with no idle gap, next word loaded;
    - otherwise go to IDLE with done_o=1 and rdy_o=1 on the same edge.
- Counters:
  - Bit-time counter counts 0..CLK_PER_SAMPLE-1 and wraps to 0 on each bit boundary.
  - Bit counter counts 0..WORD_BITS-1.
  - Word counter counts 0..nwords-1.
  - Counter widths are sized to hold their maximum value; no overflow is possible.
- Frame length: exactly (WORD_BITS+2)*CLK_PER_SAMPLE cycles per word. A request takes n*(WORD_BITS+2)*CLK_PER_SAMPLE cycles from the tx_o falling edge to done_o.
- Back-to-back requests: stb_i asserted in the done_o cycle is accepted. The next start bit follows directly after the previous stop bit (minimum 1-cycle idle between requests).
- Reset mid-frame: tx_o returns to 1 immediately. The partial frame is abandoned and no done_o is issued.
- Unused/illegal FSM encodings return to IDLE.

Optional Feature:
TUART_TX_PARITY_EN
- Defined: an EVEN parity bit (XOR of the WORD_BITS data bits) is sent for CLK_PER_SAMPLE cycles between the last data bit and the stop bit. State PARITY is added between DATA and STOP. Frame length becomes (WORD_BITS+3)*CLK_PER_SAMPLE.
- Undefined: no parity state, no parity logic; frame as above.

Test Plan:
1. Reset released, no stb_i for 100 cycles -> tx_o=1, rdy_o=1, done_o=0 throughout.
2. data_i=32'h0000_00A5, nwords_i=1, stb_i for 1 cycle (CLK_PER_SAMPLE=10) -> tx_o: 10 cycles 0, then bits 1,0,1,0,0,1,0,1 each 10 cycles, 10 cycles 1. done_o pulses exactly 100 cycles after the tx_o falling edge. rdy_o is 0 for those 100 cycles.
3. data_i=32'h4433_2211, nwords_i=4 -> bench UART decoder sees bytes 11,22,33,44 in order, no idle gap between frames, single done_o after 400 cycles.
4. nwords_i=0 with stb_i -> no activity on tx_o, no done_o. nwords_i=7 with DATA_WORDS=4 -> exactly 4 bytes sent.
5. Second stb_i with data 8'h5A asserted mid-frame of a first request sending 8'hFF -> ignored; only 8'hFF is received. stb_i with data 8'h3C in the done_o cycle -> the next frame starts on the following edge.
6. rst_in low during bit 3 of a frame -> tx_o=1 and rdy_o=1 asynchronously, before the next edge, no done_o. With TUART_TX_PARITY_EN, 8'h07 -> parity bit 1, 8'h03 -> parity bit 0, frame 110 cycles.

Source files
------------

// File: rtl/tuart_tx_if.sv
// Request/response and serial-line bundle for the tiny-UART transmitter.
// The master drives payload and strobe; the slave (tuart_tx) returns status and tx.
`timescale 1ns/1ps
interface tuart_tx_if #(
  parameter int unsigned WORD_BITS  = 8,
  parameter int unsigned DATA_WORDS = 4
);
  localparam int unsigned NwordsW = $clog2(DATA_WORDS + 1);

  logic [WORD_BITS*DATA_WORDS-1:0] data_i;
  logic [NwordsW-1:0]              nwords_i;
  logic                            stb_i;
  logic                            rdy_o;
  logic                            done_o;
  logic                            tx_o;

  modport master (
    output data_i, nwords_i, stb_i,
    input  rdy_o, done_o, tx_o
  );

  modport slave (
    input  data_i, nwords_i, stb_i,
    output rdy_o, done_o, tx_o
  );
endinterface

// File: rtl/tuart_tx.sv
// Tiny-UART transmitter: serialises up to DATA_WORDS words, LSB word first, 8N1-style frames.
// Optional even parity bit between data and stop when TUART_TX_PARITY_EN is defined.
`timescale 1ns/1ps
module tuart_tx #(
  parameter int unsigned WORD_BITS      = 8,
  parameter int unsigned DATA_WORDS     = 4,
  parameter int unsigned CLK_PER_SAMPLE = 10
) (
  input  logic      clk_i,
  input  logic      rst_in,
  tuart_tx_if.slave bus_io
);

  localparam int unsigned PayloadW = WORD_BITS * DATA_WORDS;
  localparam int unsigned TickW    = $clog2(CLK_PER_SAMPLE);
  localparam int unsigned BitW     = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
  localparam int unsigned WordW    = $clog2(DATA_WORDS + 1);

  localparam logic [TickW-1:0] TickLast = TickW'(CLK_PER_SAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_BITS - 1);
  localparam logic [WordW-1:0] WordsMax = WordW'(DATA_WORDS);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
`ifdef TUART_TX_PARITY_EN
    StParity = 3'd3,
`endif
    StStop   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TickW-1:0]    tick_q, tick_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [WordW-1:0]    word_q, word_d;
  logic [WordW-1:0]    nwords_q, nwords_d;
  logic [PayloadW-1:0] shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                rdy_q, rdy_d;
  logic                done_q, done_d;
`ifdef TUART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  logic                tick_end;
  logic [TickW-1:0]    tick_inc;
  logic [PayloadW-1:0] shifted;
  logic [WordW-1:0]    nwords_clamped;

  assign tick_end       = (tick_q == TickLast);
  assign tick_inc       = tick_end ? '0 : tick_q + 1'b1;
  // Shifting the whole payload leaves the next word at the LSB after each frame.
  assign shifted        = shift_q >> 1;
  assign nwords_clamped = (bus_io.nwords_i > WordsMax) ? WordsMax : bus_io.nwords_i;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    word_d   = word_q;
    nwords_d = nwords_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    rdy_d    = rdy_q;
    done_d   = 1'b0;
`ifdef TUART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      StIdle: begin
        tick_d = '0;
        tx_d   = 1'b1;
        rdy_d  = 1'b1;
        if (bus_io.stb_i && rdy_q && (bus_io.nwords_i != '0)) begin
          shift_d  = bus_io.data_i;
          nwords_d = nwords_clamped;
          word_d   = '0;
          bit_d    = '0;
          state_d  = StStart;
          tx_d     = 1'b0;
          rdy_d    = 1'b0;
        end
      end
      StStart: begin
        tick_d = tick_inc;
        if (tick_end) begin
          state_d = StData;
          tx_d    = shift_q[0];
`ifdef TUART_TX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      StData: begin
        tick_d = tick_inc;
        if (tick_end) begin
          shift_d = shifted;
          bit_d   = bit_q + 1'b1;
`ifdef TUART_TX_PARITY_EN
          par_d   = par_q ^ shift_q[0];
`endif
          if (bit_q == BitLast) begin
            bit_d   = '0;
`ifdef TUART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = par_q ^ shift_q[0];
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shifted[0];
          end
        end
      end
`ifdef TUART_TX_PARITY_EN
      StParity: begin
        tick_d = tick_inc;
        if (tick_end) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
`endif
      StStop: begin
        tick_d = tick_inc;
        if (tick_end) begin
          if (word_q == nwords_q - 1'b1) begin
            state_d = StIdle;
            done_d  = 1'b1;
            rdy_d   = 1'b1;
            tx_d    = 1'b1;
          end else begin
            word_d  = word_q + 1'b1;
            state_d = StStart;
            tx_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tick_d  = '0;
        bit_d   = '0;
        word_d  = '0;
        tx_d    = 1'b1;
        rdy_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      bit_q    <= '0;
      word_q   <= '0;
      nwords_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      rdy_q    <= 1'b1;
      done_q   <= 1'b0;
`ifdef TUART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      nwords_q <= nwords_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      rdy_q    <= rdy_d;
      done_q   <= done_d;
`ifdef TUART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign bus_io.tx_o   = tx_q;
  assign bus_io.rdy_o  = rdy_q;
  assign bus_io.done_o = done_q;

endmodule

// File: tb/tb_tuart_tx.sv
// Directed bench for tuart_tx: a bit-level UART decoder pops expected bytes from a scoreboard
// queue; the main sequence checks handshake timing, clamping, back-to-back and async reset.
`timescale 1ns/1ps
module tb_tuart_tx;
  localparam int unsigned WB  = 8;
  localparam int unsigned DW  = 4;
  localparam int unsigned CPS = 10;
`ifdef TUART_TX_PARITY_EN
  localparam int FrameLen = (WB + 3) * CPS;
`else
  localparam int FrameLen = (WB + 2) * CPS;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  tuart_tx_if #(.WORD_BITS(WB), .DATA_WORDS(DW)) bus ();

  tuart_tx #(
    .WORD_BITS      (WB),
    .DATA_WORDS     (DW),
    .CLK_PER_SAMPLE (CPS)
  ) dut (
    .clk_i  (clk),
    .rst_in (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int tests    = 0;
  int fails    = 0;
  int cyc      = 0;
  int rx_cnt   = 0;
  int done_cnt = 0;
  bit mon_en   = 1'b0;
  bit rst_hit  = 1'b0;
  logic [7:0] exp_q[$];
  int         start_q[$];
`ifdef TUART_TX_PARITY_EN
  logic       last_par = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(negedge rst_n);
    rst_hit = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (mon_en && bus.done_o === 1'b1) done_cnt++;
  end

  // UART decoder: samples each bit at its centre, aborts frames interrupted by reset.
  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n && bus.tx_o === 1'b0) begin
      automatic logic [7:0] b = '0;
      automatic logic       stop_bit;
      automatic logic [7:0] e;
`ifdef TUART_TX_PARITY_EN
      automatic logic       p;
`endif
      rst_hit = 1'b0;
      start_q.push_back(cyc);
      repeat (CPS / 2) @(negedge clk);
      for (int i = 0; i < int'(WB); i++) begin
        repeat (CPS) @(negedge clk);
        b[i] = bus.tx_o;
      end
`ifdef TUART_TX_PARITY_EN
      repeat (CPS) @(negedge clk);
      p = bus.tx_o;
`endif
      repeat (CPS) @(negedge clk);
      stop_bit = bus.tx_o;
      if (!rst_hit) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL rx_unexpected: observed %0h expected none", b);
        end else begin
          e = exp_q.pop_front();
          chk("rx_byte", {24'h0, b}, {24'h0, e});
          chk("rx_stop", {31'h0, stop_bit}, 32'h1);
`ifdef TUART_TX_PARITY_EN
          chk("rx_parity", {31'h0, p}, {31'h0, ^e});
          last_par = p;
`endif
        end
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic [2:0] n);
    @(negedge clk);
    bus.data_i   = d;
    bus.nwords_i = n;
    bus.stb_i    = 1'b1;
    @(negedge clk);
    bus.stb_i    = 1'b0;
  endtask

  // Returns at the negedge where done_o is seen, counting rdy_o-low samples before it.
  task automatic wait_done(input int budget, output int low, output int dcyc);
    bit seen;
    seen = 1'b0;
    low  = 0;
    dcyc = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        dcyc = cyc;
      end else if (bus.rdy_o === 1'b0) begin
        low++;
      end
    end
    chk("done_seen", {31'h0, seen}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, dc, bad, d0, r0;
    bus.stb_i    = 1'b0;
    bus.data_i   = '0;
    bus.nwords_i = '0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'h0, bus.tx_o}, 32'h1);
    chk("rst_rdy", {31'h0, bus.rdy_o}, 32'h1);
    chk("rst_done", {31'h0, bus.done_o}, 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx_o !== 1'b1 || bus.rdy_o !== 1'b1 || bus.done_o !== 1'b0) bad++;
    end
    chk("idle_100", bad, 0);

    // Single word 0xA5
    start_q.delete();
    exp_q.push_back(8'hA5);
    r0 = rx_cnt;
    send(32'h0000_00A5, 3'd1);
    chk("latency_tx", {31'h0, bus.tx_o}, 32'h0);
    chk("latency_rdy", {31'h0, bus.rdy_o}, 32'h0);
    wait_done(FrameLen + 20, low, dc);
    chk("rdy_at_done", {31'h0, bus.rdy_o}, 32'h1);
    chk("rdy_low_1w", low, FrameLen - 1);
    chk("done_lat_1w", dc - start_q[0], FrameLen);
    @(negedge clk);
    chk("done_pulse_1", {31'h0, bus.done_o}, 32'h0);
    repeat (5) @(negedge clk);
    chk("rx_cnt_1w", rx_cnt - r0, 1);

    // Four words, no idle gap
    start_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    r0 = rx_cnt;
    d0 = done_cnt;
    send(32'h4433_2211, 3'd4);
    wait_done(4 * FrameLen + 20, low, dc);
    chk("rdy_low_4w", low, 4 * FrameLen - 1);
    chk("done_lat_4w", dc - start_q[0], 4 * FrameLen);
    chk("starts_4w", start_q.size(), 4);
    for (int i = 1; i < 4; i++) chk("gap_4w", start_q[i] - start_q[i-1], FrameLen);
    repeat (5) @(negedge clk);
    chk("done_cnt_4w", done_cnt - d0, 1);
    chk("rx_cnt_4w", rx_cnt - r0, 4);

    // nwords=0 ignored, nwords=7 clamped to 4
    d0 = done_cnt;
    send(32'hFFFF_FFFF, 3'd0);
    bad = 0;
    repeat (FrameLen + 20) begin
      @(negedge clk);
      if (bus.tx_o !== 1'b1 || bus.rdy_o !== 1'b1) bad++;
    end
    chk("nw0_idle", bad, 0);
    chk("nw0_done", done_cnt - d0, 0);
    start_q.delete();
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
    r0 = rx_cnt;
    send(32'hDDCC_BBAA, 3'd7);
    wait_done(4 * FrameLen + 20, low, dc);
    chk("done_lat_clamp", dc - start_q[0], 4 * FrameLen);
    repeat (5) @(negedge clk);
    chk("rx_cnt_clamp", rx_cnt - r0, 4);

    // Strobe mid-frame ignored; strobe in done cycle accepted
    start_q.delete();
    r0 = rx_cnt;
    d0 = done_cnt;
    exp_q.push_back(8'hFF);
    send(32'h0000_00FF, 3'd1);
    repeat (30) @(negedge clk);
    send(32'h0000_005A, 3'd1);
    wait_done(FrameLen + 20, low, dc);
    repeat (3) @(negedge clk);
    start_q.delete();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send(32'h0000_00FF, 3'd1);
    wait_done(FrameLen + 20, low, dc);
    bus.data_i   = 32'h0000_003C;
    bus.nwords_i = 3'd1;
    bus.stb_i    = 1'b1;
    @(negedge clk);
    bus.stb_i    = 1'b0;
    chk("b2b_tx", {31'h0, bus.tx_o}, 32'h0);
    chk("b2b_rdy", {31'h0, bus.rdy_o}, 32'h0);
    wait_done(FrameLen + 20, low, bad);
    chk("b2b_start", start_q[1], dc + 1);
    repeat (5) @(negedge clk);
    chk("rx_cnt_b2b", rx_cnt - r0, 3);
    chk("done_cnt_b2b", done_cnt - d0, 3);
    chk("exp_empty_b2b", exp_q.size(), 0);

    // Asynchronous reset during data bit 3
    r0 = rx_cnt;
    d0 = done_cnt;
    send(32'h0000_0055, 3'd1);
    repeat (45) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {31'h0, bus.tx_o}, 32'h1);
    chk("async_rst_rdy", {31'h0, bus.rdy_o}, 32'h1);
    chk("async_rst_done", {31'h0, bus.done_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FrameLen + 20) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_rx", rx_cnt - r0, 0);
    start_q.delete();
    exp_q.push_back(8'h96);
    send(32'h0000_0096, 3'd1);
    wait_done(FrameLen + 20, low, dc);
    chk("done_lat_post_rst", dc - start_q[0], FrameLen);

`ifdef TUART_TX_PARITY_EN
    start_q.delete();
    exp_q.push_back(8'h07);
    send(32'h0000_0007, 3'd1);
    wait_done(FrameLen + 20, low, dc);
    chk("frame_len_par", dc - start_q[0], 110);
    repeat (5) @(negedge clk);
    chk("parity_07", {31'h0, last_par}, 32'h1);
    exp_q.push_back(8'h03);
    send(32'h0000_0003, 3'd1);
    wait_done(FrameLen + 20, low, dc);
    repeat (5) @(negedge clk);
    chk("parity_03", {31'h0, last_par}, 32'h0);
`endif

    repeat (10) @(negedge clk);
    chk("exp_empty_end", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
